// File: rtl/smp_mem_pkg.sv
// rtl/smp_mem_pkg.sv - shared types and constants for the SMP memory arbiter
package smp_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam int REQ_CPU    = 0;
  localparam int REQ_LOADER = 1;
  localparam int REQ_IO     = 2;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 8;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick: first requester at or after ptr
module rr_picker #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            any_req
);

  int c;

  // Scan from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    onehot  = '0;
    idx     = '0;
    any_req = |req;
    c       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      if (req[c[PW-1:0]]) begin
        onehot              = '0;
        onehot[c[PW-1:0]]   = 1'b1;
        idx                 = c[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter with bounded burst lock for the shared SMP memory
module mem_arbiter
  import smp_mem_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int WAIT_STATES = 1,
  parameter int MAX_LOCK    = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic [DW-1:0]        rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int LW = $clog2(MAX_LOCK + 1);

  localparam logic [WW-1:0] WS_INIT   = WW'(WAIT_STATES);
  localparam logic [WW-1:0] W_ONE     = WW'(1);
  localparam logic [LW-1:0] L_ONE     = LW'(1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(MAX_LOCK - 1);
  localparam logic [PW-1:0] P_ONE     = PW'(1);
  localparam logic [PW-1:0] P_LAST    = PW'(NREQ - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [LW-1:0]   lock_q, lock_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic [NREQ-1:0] pick_onehot;
  logic [PW-1:0]   pick_idx;
  logic            any_req;
  logic [PW-1:0]   sel_idx;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            lock_ok;
  logic [PW-1:0]   next_ptr;

  rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .onehot  (pick_onehot),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  // Fresh grants sample the picker's winner; locked re-issues sample the current owner.
  always_comb begin
    sel_idx   = (state_q == ACK) ? gidx_q : pick_idx;
    sel_we    = req_we[sel_idx];
    sel_addr  = req_addr[int'(sel_idx)*AW +: AW];
    sel_wdata = req_wdata[int'(sel_idx)*DW +: DW];
    lock_ok   = req[gidx_q] & req_lock[gidx_q] & (lock_q < LOCK_LAST);
    next_ptr  = (gidx_q == P_LAST) ? '0 : gidx_q + P_ONE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      lock_q  <= '0;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      lock_q  <= lock_d;
      wcnt_q  <= wcnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (wcnt_q == '0) state_d = ACK;
      ACK:     state_d = lock_ok ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    lock_d  = lock_q;
    wcnt_d  = wcnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gidx_d  = pick_idx;
          gnt_d   = pick_onehot;
          lock_d  = '0;
          wcnt_d  = WS_INIT;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
        end
      end
      ACCESS: begin
        if (wcnt_q == '0) begin
          if (!we_q) rdata_d = mem_rdata;
        end else begin
          wcnt_d = wcnt_q - W_ONE;
        end
      end
      ACK: begin
        ptr_d = next_ptr;
        if (lock_ok) begin
          lock_d  = lock_q + L_ONE;
          wcnt_d  = WS_INIT;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
        end else begin
          gnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_en = (state_q == ACCESS);
    mem_we = (state_q == ACCESS) & we_q;
    ack    = (state_q == ACK) ? gnt_q : '0;
    busy   = (state_q != IDLE);
  end

  assign gnt       = gnt_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  import smp_mem_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = DEF_AW;
  localparam int DW   = DEF_DW;
  localparam int WS   = 1;
  localparam int MAXL = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [NREQ-1:0]    req, req_we, req_lock;
  logic [AW-1:0]      addr [NREQ];
  logic [DW-1:0]      wdat [NREQ];
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt, ack;
  logic [DW-1:0]      rdata, mem_wdata, mem_rdata;
  logic               mem_en, mem_we, busy;
  logic [AW-1:0]      mem_addr;

  assign req_addr  = {addr[2], addr[1], addr[0]};
  assign req_wdata = {wdat[2], wdat[1], wdat[0]};

  logic [NREQ-1:0]    r0_req, r0_we, r0_lock, r0_gnt, r0_ack;
  logic [NREQ*AW-1:0] r0_addr;
  logic [NREQ*DW-1:0] r0_wdata;
  logic [DW-1:0]      r0_rdata, r0_mem_wdata, r0_mem_rdata;
  logic               r0_mem_en, r0_mem_we, r0_busy;
  logic [AW-1:0]      r0_mem_addr;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  assign mem_rdata    = mem[mem_addr];
  assign r0_mem_rdata = mem[r0_mem_addr];

  mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .WAIT_STATES(WS), .MAX_LOCK(MAXL)) dut (
    .clock(clock), .reset(reset), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .WAIT_STATES(0), .MAX_LOCK(MAXL)) dut0 (
    .clock(clock), .reset(reset), .req(r0_req), .req_we(r0_we), .req_lock(r0_lock),
    .req_addr(r0_addr), .req_wdata(r0_wdata), .gnt(r0_gnt), .ack(r0_ack), .rdata(r0_rdata),
    .mem_en(r0_mem_en), .mem_we(r0_mem_we), .mem_addr(r0_mem_addr), .mem_wdata(r0_mem_wdata),
    .mem_rdata(r0_mem_rdata), .busy(r0_busy)
  );

  typedef struct {
    int         idx;
    logic       we;
    logic [15:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   ack_log[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   exp3[6] = '{1, 1, 1, 1, 0, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bench memory: the DUT-side array, written only by DUT write cycles.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'hA5;
    mem[16'h0020] = 8'h5A;
    forever begin
      @(posedge clock);
      if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  // Transaction-level reference: each access occupies WS+1 cycles then one ack cycle.
  int m_ptr, m_owner, m_t, m_lock, m_w;
  bit m_active;
  logic [7:0] m_rdata;

  task automatic issue(input int w);
    exp_t e;
    m_active = 1'b1;
    m_owner  = w;
    m_t      = 0;
    e.idx    = w;
    e.we     = req_we[w];
    e.addr   = addr[w];
    e.wdata  = wdat[w];
    e.cyc    = cyc + WS + 1;
    if (e.we) ref_mem[e.addr] = e.wdata;
    else      m_rdata = ref_mem[e.addr];
    e.rdata  = m_rdata;
    exp_q.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    ref_mem[16'h0010] = 8'hA5;
    ref_mem[16'h0020] = 8'h5A;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_active = 1'b0; m_ptr = 0; m_t = 0; m_lock = 0; m_rdata = 8'h00;
        exp_q.delete();
      end else begin
        cyc++;
        if (m_active) begin
          m_t++;
          if (m_t == WS + 2) begin
            m_ptr = (m_owner + 1) % NREQ;
            if (req[m_owner] && req_lock[m_owner] && m_lock < MAXL - 1) begin
              m_lock++;
              issue(m_owner);
            end else begin
              m_active = 1'b0;
            end
          end
        end else if (req != '0) begin
          m_w = -1;
          for (int k = 0; k < NREQ; k++)
            if (m_w < 0 && req[(m_ptr + k) % NREQ]) m_w = (m_ptr + k) % NREQ;
          m_lock = 0;
          issue(m_w);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        check("gnt_onehot", 32'($onehot0(gnt)), 1);
        check("ack_onehot", 32'($onehot0(ack)), 1);
        if (exp_q.size() == 0) begin
          check("idle_gnt", 32'(gnt), 0);
          check("idle_ack", 32'(ack), 0);
          check("idle_mem_en", 32'(mem_en), 0);
          check("idle_busy", 32'(busy), 0);
        end else begin
          mon_e = exp_q[0];
          check("owner_gnt", 32'(gnt), 32'(1 << mon_e.idx));
          check("owner_busy", 32'(busy), 1);
          if (cyc == mon_e.cyc) begin
            check("ack_owner", 32'(ack), 32'(1 << mon_e.idx));
            check("ack_mem_en", 32'(mem_en), 0);
            check("ack_rdata", 32'(rdata), 32'(mon_e.rdata));
            ack_log.push_back(mon_e.idx);
            void'(exp_q.pop_front());
          end else begin
            check("access_ack", 32'(ack), 0);
            check("access_mem_en", 32'(mem_en), 1);
            check("access_mem_we", 32'(mem_we), 32'(mon_e.we));
            check("access_addr", 32'(mem_addr), 32'(mon_e.addr));
            check("access_wdata", 32'(mem_wdata), 32'(mon_e.wdata));
          end
        end
      end
    end
  end

  task automatic wait_acks(input int n, input string name);
    int lim;
    lim = 300;
    while (ack_log.size() < n && lim > 0) begin
      @(posedge clock);
      lim--;
    end
    #1;
    check({name, "_ack_timeout"}, 32'(ack_log.size() >= n), 1);
  endtask

  task automatic wait_gnt(input int i, input string name);
    int lim;
    lim = 50;
    do begin
      @(posedge clock);
      #1;
      lim--;
    end while (!gnt[i] && lim > 0);
    check({name, "_gnt"}, 32'(gnt[i]), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  int n1, lim, last, run, nacks;

  initial begin
    req = '0; req_we = '0; req_lock = '0;
    for (int i = 0; i < NREQ; i++) begin addr[i] = '0; wdat[i] = '0; end
    r0_req = '0; r0_we = '0; r0_lock = '0; r0_wdata = '0;
    r0_addr = {16'h0000, 16'h0000, 16'h0020};
    idle(3);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b1;

    // Single CPU read.
    addr[REQ_CPU] = 16'h0010;
    req = 3'b001;
    @(posedge clock); #1;
    check("t1_gnt", 32'(gnt), 1);
    wait_acks(1, "t1");
    req = '0;
    check("t1_ack_idx", 32'(ack_log[0]), 0);
    check("t1_rdata", 32'(rdata), 32'hA5);

    // All three request continuously: strict rotation starting at ptr=1.
    ack_log.delete();
    for (int i = 0; i < NREQ; i++) addr[i] = 16'h0040 + 16'(i);
    req = 3'b111;
    wait_acks(6, "t2");
    req = '0;
    check("t2_first", 32'(ack_log[0]), 1);
    for (int i = 1; i < 6; i++) check("t2_rotation", 32'(ack_log[i]), 32'((ack_log[0] + i) % 3));
    idle(2);

    // Loader burst under lock with the CPU competing.
    ack_log.delete();
    addr[REQ_LOADER] = 16'h0100; wdat[REQ_LOADER] = 8'($urandom);
    addr[REQ_CPU] = 16'h0010;
    req_we = 3'b010; req_lock = 3'b010; req = 3'b011;
    n1 = 0; lim = 200;
    while (n1 < 6 && lim > 0) begin
      @(negedge clock);
      lim--;
      if (ack[1]) begin
        n1++;
        addr[REQ_LOADER]++;
        wdat[REQ_LOADER] = 8'($urandom);
        if (n1 == 6) begin req = '0; req_lock = '0; end
      end
    end
    check("t3_loader_acks", 32'(n1), 6);
    idle(3);
    for (int i = 0; i < 6; i++) check("t3_order", 32'(ack_log[i]), 32'(exp3[i]));
    for (int i = 0; i < 6; i++) check("t3_mem", 32'(mem[16'h0100 + 16'(i)]), 32'(ref_mem[16'h0100 + 16'(i)]));

    // IO write that drops its request mid-access.
    ack_log.delete();
    req_we = 3'b100; addr[REQ_IO] = 16'hFFFF; wdat[REQ_IO] = 8'h3C; req = 3'b100;
    wait_gnt(REQ_IO, "t4");
    @(posedge clock); #1;
    req = '0;
    wait_acks(1, "t4");
    check("t4_ack_idx", 32'(ack_log[0]), 2);
    check("t4_mem", 32'(mem[16'hFFFF]), 32'h3C);
    idle(2);

    // Reset during the second access cycle aborts the access.
    ack_log.delete();
    req_we = '0; addr[REQ_LOADER] = 16'h0010; req = 3'b010;
    wait_acks(1, "t5a");
    req = '0;
    idle(1);
    addr[REQ_CPU] = 16'h0030; req = 3'b001;
    wait_gnt(REQ_CPU, "t5");
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    check("t5_mem_en", 32'(mem_en), 0);
    check("t5_mem_we", 32'(mem_we), 0);
    check("t5_gnt", 32'(gnt), 0);
    check("t5_ack", 32'(ack), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_rdata", 32'(rdata), 0);
    req = 3'b111;
    idle(3);
    ack_log.delete();
    reset = 1'b1;
    wait_acks(1, "t5b");
    req = '0;
    check("t5_first_after_reset", 32'(ack_log[0]), 0);
    idle(3);

    // Randomized traffic over a small address window.
    for (int c = 0; c < 1500; c++) begin
      req = 3'($urandom); req_lock = 3'($urandom); req_we = 3'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        addr[i] = 16'($urandom_range(0, 15));
        wdat[i] = 8'($urandom);
      end
      idle(1);
    end
    req = '0; req_lock = '0;
    idle(12);
    for (int a = 0; a < 16; a++) check("rand_mem", 32'(mem[a]), 32'(ref_mem[a]));

    // Zero-wait-state build: back-to-back CPU reads.
    r0_req = 3'b001;
    last = -1; run = 0; nacks = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      check("t6_gnt_onehot", 32'($onehot0(r0_gnt)), 1);
      check("t6_mem_we", 32'(r0_mem_we), 0);
      if (r0_mem_en) run++;
      else if (run > 0) begin
        check("t6_mem_en_len", 32'(run), 1);
        run = 0;
      end
      if (r0_ack != '0) begin
        check("t6_ack", 32'(r0_ack), 1);
        check("t6_rdata", 32'(r0_rdata), 32'h5A);
        if (last >= 0) check("t6_period", 32'(c - last), 3);
        last = c;
        nacks++;
      end
    end
    r0_req = '0;
    check("t6_ack_count", 32'(nacks >= 5), 1);
    idle(4);
    check("t6_idle_busy", 32'(r0_busy), 0);
    check("t6_mem_wdata", 32'(r0_mem_wdata), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
